// File: rtl/psum_sc_mc_ctrl_pkg.sv
// Shared definitions for the multi-channel partial-sum scratchpad controller:
// FSM state encoding and accumulate-select constants.
package psum_sc_mc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_WAIT  = 3'd0,
    ST_RD    = 3'd1,
    ST_RDREG = 3'd2,
    ST_WR    = 3'd3,
    ST_OUT   = 3'd4,
    ST_CLR   = 3'd5,
    ST_DONE  = 3'd6
  } state_e;

  localparam logic ACC_SEL_PASS = 1'b0;
  localparam logic ACC_SEL_ADD  = 1'b1;

endpackage

// File: rtl/psum_sc_mc_datapath.sv
// Datapath for the psum scratchpad controller: wrapping lead pointer, channel
// counter with runtime limit, latched per-position flags and address concat.
module psum_sc_mc_datapath
  import psum_sc_mc_ctrl_pkg::*;
#(
  parameter int ADDR_LEN  = 8,
  parameter int DEPTH     = 256,
  parameter int NUM_CH    = 4,
  parameter int CH_ID_LEN = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          accept_i,
  input  logic                          finish_step_i,
  input  logic                          first_pass_i,
  input  logic [CH_ID_LEN-1:0]          active_ch_i,
  input  logic                          clear_i,
  input  logic                          ch_step_i,
  input  logic                          lead_step_i,
  output logic [CH_ID_LEN-1:0]          ch_sel_o,
  output logic [ADDR_LEN-1:0]           lead_o,
  output logic                          fin_o,
  output logic                          ovw_o,
  output logic                          ch_last_o,
  output logic                          lead_wrap_o,
  output logic [ADDR_LEN+CH_ID_LEN-1:0] addr_o
);

  localparam logic [CH_ID_LEN-1:0] CH_MAX   = CH_ID_LEN'(NUM_CH - 1);
  localparam logic [ADDR_LEN-1:0]  LEAD_MAX = ADDR_LEN'(DEPTH - 1);

  logic [ADDR_LEN-1:0]  lead_q, lead_d;
  logic [CH_ID_LEN-1:0] ch_q, ch_d;
  logic [CH_ID_LEN-1:0] nch_q, nch_d;
  logic                 fin_q, fin_d;
  logic                 ovw_q, ovw_d;
  logic [CH_ID_LEN-1:0] nch_clamped;
  logic                 lead_at_max;
  logic                 ch_last;

  assign nch_clamped = (active_ch_i > CH_MAX) ? CH_MAX : active_ch_i;
  assign lead_at_max = (lead_q == LEAD_MAX);
  assign ch_last     = (ch_q == nch_q);

  // The channel limit is only captured on a position's first channel so that
  // later channels of the same position cannot change it mid-flight.
  always_comb begin
    lead_d = lead_q;
    ch_d   = ch_q;
    nch_d  = nch_q;
    fin_d  = fin_q;
    ovw_d  = ovw_q;
    if (clear_i) begin
      lead_d = '0;
      ch_d   = '0;
    end
    if (accept_i) begin
      fin_d = fin_q | finish_step_i;
      ovw_d = first_pass_i;
      if (ch_q == '0) nch_d = nch_clamped;
    end
    if (ch_step_i) ch_d = ch_last ? '0 : ch_q + 1'b1;
    if (lead_step_i) begin
      lead_d = lead_at_max ? '0 : lead_q + 1'b1;
      fin_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lead_q <= '0;
      ch_q   <= '0;
      nch_q  <= '0;
      fin_q  <= 1'b0;
      ovw_q  <= 1'b0;
    end else begin
      lead_q <= lead_d;
      ch_q   <= ch_d;
      nch_q  <= nch_d;
      fin_q  <= fin_d;
      ovw_q  <= ovw_d;
    end
  end

  assign ch_sel_o    = ch_q;
  assign lead_o      = lead_q;
  assign fin_o       = fin_q;
  assign ovw_o       = ovw_q;
  assign ch_last_o   = ch_last;
  assign lead_wrap_o = lead_step_i & lead_at_max;
  assign addr_o      = {lead_q, ch_q};

endmodule

// File: rtl/psum_sc_mc_ctrl.sv
// Partial-sum scratchpad controller: sequences read-modify-write per channel
// between the PE pipeline and the psum scratchpad, then flushes the position.
module psum_sc_mc_ctrl
  import psum_sc_mc_ctrl_pkg::*;
#(
  parameter int PSUM_SC_ADDR_LEN = 8,
  parameter int PSUM_SC_DEPTH    = 256,
  parameter int NUM_CH           = 4,
  parameter int CH_ID_LEN        = 2
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  psum_valid_i,
  input  logic                                  finish_step_i,
  input  logic                                  first_pass_i,
  input  logic [CH_ID_LEN-1:0]                  active_ch_i,
  input  logic                                  clear_lead_i,
  output logic                                  stall_pipeline_o,
  output logic                                  psum_sc_ren_o,
  output logic                                  psum_sc_wen_o,
  output logic [PSUM_SC_ADDR_LEN+CH_ID_LEN-1:0] psum_sc_addr_o,
  output logic [CH_ID_LEN-1:0]                  ch_sel_o,
  output logic                                  acc_sel_o,
  output logic                                  psum_sc_reg_en_o,
  output logic                                  regs_en_o,
  output logic                                  clear_regs_o,
  output logic                                  psum_sc_done_o,
  output logic                                  lead_wrap_o,
  output logic [PSUM_SC_ADDR_LEN-1:0]           psum_sc_cnt_lead_o
);

  state_e state_q, state_d;
  logic   accept, clear, ch_step, lead_step;
  logic   fin_l, ovw_l, ch_last;

  psum_sc_mc_datapath #(
    .ADDR_LEN (PSUM_SC_ADDR_LEN),
    .DEPTH    (PSUM_SC_DEPTH),
    .NUM_CH   (NUM_CH),
    .CH_ID_LEN(CH_ID_LEN)
  ) u_datapath (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .accept_i     (accept),
    .finish_step_i(finish_step_i),
    .first_pass_i (first_pass_i),
    .active_ch_i  (active_ch_i),
    .clear_i      (clear),
    .ch_step_i    (ch_step),
    .lead_step_i  (lead_step),
    .ch_sel_o     (ch_sel_o),
    .lead_o       (psum_sc_cnt_lead_o),
    .fin_o        (fin_l),
    .ovw_o        (ovw_l),
    .ch_last_o    (ch_last),
    .lead_wrap_o  (lead_wrap_o),
    .addr_o       (psum_sc_addr_o)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_WAIT;
    else       state_q <= state_d;
  end

  // A clear_lead in WAIT takes priority and defers any coincident psum_valid.
  always_comb begin
    state_d          = state_q;
    accept           = 1'b0;
    clear            = 1'b0;
    ch_step          = 1'b0;
    lead_step        = 1'b0;
    stall_pipeline_o = 1'b0;
    psum_sc_ren_o    = 1'b0;
    psum_sc_wen_o    = 1'b0;
    acc_sel_o        = ACC_SEL_PASS;
    psum_sc_reg_en_o = 1'b0;
    regs_en_o        = 1'b0;
    clear_regs_o     = 1'b0;
    psum_sc_done_o   = 1'b0;
    case (state_q)
      ST_WAIT: begin
        if (clear_lead_i) begin
          clear = 1'b1;
        end else if (psum_valid_i) begin
          accept  = 1'b1;
          state_d = first_pass_i ? ST_WR : ST_RD;
        end
      end
      ST_RD: begin
        psum_sc_ren_o    = 1'b1;
        stall_pipeline_o = 1'b1;
        state_d          = ST_RDREG;
      end
      ST_RDREG: begin
        psum_sc_reg_en_o = 1'b1;
        stall_pipeline_o = 1'b1;
        state_d          = ST_WR;
      end
      ST_WR: begin
        psum_sc_wen_o    = 1'b1;
        stall_pipeline_o = 1'b1;
        acc_sel_o        = ovw_l ? ACC_SEL_PASS : ACC_SEL_ADD;
        ch_step          = 1'b1;
        state_d          = (ch_last && fin_l) ? ST_OUT : ST_WAIT;
      end
      ST_OUT: begin
        regs_en_o        = 1'b1;
        stall_pipeline_o = 1'b1;
        state_d          = ST_CLR;
      end
      ST_CLR: begin
        clear_regs_o     = 1'b1;
        stall_pipeline_o = 1'b1;
        state_d          = ST_DONE;
      end
      ST_DONE: begin
        psum_sc_done_o = 1'b1;
        lead_step      = 1'b1;
        state_d        = ST_WAIT;
      end
      default: state_d = ST_WAIT;
    endcase
  end

endmodule
